// File: rtl/clint_pkg.sv
// ---------------------------------------------------------------------------
// clint_pkg
// Shared definitions for the core-local interruptor (CLINT):
//   - data/strobe widths of the AXI4-Lite port
//   - register offsets for msip, mtimecmp and mtime
//   - AXI response code used for every response
//   - register selector enum, word-address decoder and byte-strobe merge helper
// ---------------------------------------------------------------------------
package clint_pkg;

    localparam int unsigned CLINT_DATA_W = 64;
    localparam int unsigned CLINT_STRB_W = CLINT_DATA_W / 8;

    localparam logic [15:0] CLINT_MSIP_OFS     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFS = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFS    = 16'hBFF8;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        REG_NONE     = 2'd0,
        REG_MSIP     = 2'd1,
        REG_MTIMECMP = 2'd2,
        REG_MTIME    = 2'd3
    } clintReg_e;

    // Decodes a 64-bit word offset (address bits [15:3]) to a register.
    function automatic clintReg_e decodeWord(input logic [12:0] word);
        clintReg_e sel;
        sel = REG_NONE;
        if (word == CLINT_MSIP_OFS[15:3]) begin
            sel = REG_MSIP;
        end else if (word == CLINT_MTIMECMP_OFS[15:3]) begin
            sel = REG_MTIMECMP;
        end else if (word == CLINT_MTIME_OFS[15:3]) begin
            sel = REG_MTIME;
        end
        return sel;
    endfunction

    // Replaces the bytes of oldVal selected by strb with the bytes of newVal.
    function automatic logic [CLINT_DATA_W-1:0] mergeStrb(
        input logic [CLINT_DATA_W-1:0] oldVal,
        input logic [CLINT_DATA_W-1:0] newVal,
        input logic [CLINT_STRB_W-1:0] strb
    );
        logic [CLINT_DATA_W-1:0] res;
        res = oldVal;
        for (int b = 0; b < int'(CLINT_STRB_W); b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = newVal[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// ---------------------------------------------------------------------------
// clint_timer
// Free-running 64-bit mtime counter with byte-strobe write, optional tick
// prescaler and the registered machine timer interrupt compare.
//
// Optional feature macro: CLINT_RTC_DIV_EN
//   defined   : a 16-bit prescaler produces one tick every RTC_DIV clocks
//   undefined : mtime advances on every clock, RTC_DIV is unused
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   mtimeWe_i    write strobe for mtime (already decoded by the AXI side)
//   wData_i      write data
//   wStrb_i      byte-write enables
//   mtimecmp_i   current mtimecmp register value
//   mtime_o      current mtime value
//   mti_o        machine timer interrupt, registered (mtime >= mtimecmp)
// ---------------------------------------------------------------------------
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned RTC_DIV = 100
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    mtimeWe_i,
    input  logic [CLINT_DATA_W-1:0] wData_i,
    input  logic [CLINT_STRB_W-1:0] wStrb_i,
    input  logic [CLINT_DATA_W-1:0] mtimecmp_i,
    output logic [CLINT_DATA_W-1:0] mtime_o,
    output logic                    mti_o
);

    logic                    tick;
    logic [CLINT_DATA_W-1:0] mtime_q;
    logic [CLINT_DATA_W-1:0] mtime_d;
    logic [CLINT_DATA_W-1:0] mtimeInc;
    logic                    mti_q;

`ifdef CLINT_RTC_DIV_EN
    localparam logic [15:0] DivLast = 16'(RTC_DIV - 1);

    logic [15:0] prescale_q;
    logic [15:0] prescale_d;

    // Prescaler counts 0..RTC_DIV-1; the tick is the reload cycle.
    // Any mtime write restarts the count so the next tick is a full period away.
    always_comb begin
        tick       = 1'b0;
        prescale_d = prescale_q + 16'd1;
        if (prescale_q == DivLast) begin
            tick       = 1'b1;
            prescale_d = '0;
        end
        if (mtimeWe_i) begin
            prescale_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end
`else
    logic unusedRtcDiv;
    assign unusedRtcDiv = ^RTC_DIV;
    assign tick         = 1'b1;
`endif

    // A write landing on a tick edge merges over the incremented value, so
    // unwritten bytes still carry the increment.
    always_comb begin
        mtimeInc = tick ? (mtime_q + 64'd1) : mtime_q;
        mtime_d  = mtimeInc;
        if (mtimeWe_i) begin
            mtime_d = mergeStrb(mtimeInc, wData_i, wStrb_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q <= '0;
        end else begin
            mtime_q <= mtime_d;
        end
    end

    // Compare on the registered values; the interrupt lags the condition by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mti_q <= 1'b0;
        end else begin
            mti_q <= (mtime_q >= mtimecmp_i);
        end
    end

    assign mtime_o = mtime_q;
    assign mti_o   = mti_q;

endmodule

// File: rtl/axi_clint.sv
// ---------------------------------------------------------------------------
// axi_clint
// AXI4-Lite responder for the RISC-V core-local interruptor. Holds msip and
// mtimecmp, hosts the mtime timer (clint_timer) and drives MSI / MTI.
//
// Optional feature macro: CLINT_RTC_DIV_EN (tick prescaler inside clint_timer).
//
// Ports:
//   CLK, RSTn               clock (rising edge) and async active-low reset
//   CLINT_AXI_AW*           write address channel, address bits [15:3] decoded
//   CLINT_AXI_W*            write data channel with byte strobes
//   CLINT_AXI_B*            write response, always OKAY
//   CLINT_AXI_AR*           read address channel, address bits [15:3] decoded
//   CLINT_AXI_R*            read data channel, always OKAY
//   MSI                     machine software interrupt (msip bit 0)
//   MTI                     machine timer interrupt (registered compare)
// ---------------------------------------------------------------------------
module axi_clint
    import clint_pkg::*;
#(
    parameter int unsigned RTC_DIV = 100
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic [63:0]             CLINT_AXI_AWADDR,
    input  logic                    CLINT_AXI_AWVALID,
    output logic                    CLINT_AXI_AWREADY,
    input  logic [CLINT_DATA_W-1:0] CLINT_AXI_WDATA,
    input  logic [CLINT_STRB_W-1:0] CLINT_AXI_WSTRB,
    input  logic                    CLINT_AXI_WVALID,
    output logic                    CLINT_AXI_WREADY,
    output logic [1:0]              CLINT_AXI_BRESP,
    output logic                    CLINT_AXI_BVALID,
    input  logic                    CLINT_AXI_BREADY,
    input  logic [63:0]             CLINT_AXI_ARADDR,
    input  logic                    CLINT_AXI_ARVALID,
    output logic                    CLINT_AXI_ARREADY,
    output logic [CLINT_DATA_W-1:0] CLINT_AXI_RDATA,
    output logic [1:0]              CLINT_AXI_RRESP,
    output logic                    CLINT_AXI_RVALID,
    input  logic                    CLINT_AXI_RREADY,
    output logic                    MSI,
    output logic                    MTI
);

    logic                    awFull_q;
    logic [12:0]             awAddr_q;
    logic                    wFull_q;
    logic [CLINT_DATA_W-1:0] wData_q;
    logic [CLINT_STRB_W-1:0] wStrb_q;
    logic                    bValid_q;
    logic                    rValid_q;
    logic [CLINT_DATA_W-1:0] rData_q;
    logic                    msip_q;
    logic [CLINT_DATA_W-1:0] mtimecmp_q;

    logic                    awHs;
    logic                    wHs;
    logic                    arHs;
    logic                    doWrite;
    logic [12:0]             wrWord;
    logic [CLINT_DATA_W-1:0] wrData;
    logic [CLINT_STRB_W-1:0] wrStrb;
    clintReg_e               wrReg;
    logic                    mtimeWe;
    logic [CLINT_DATA_W-1:0] mtime;
    logic [CLINT_DATA_W-1:0] rdMux;
    logic                    unusedAddrBits;

    assign unusedAddrBits = ^{CLINT_AXI_AWADDR[63:16], CLINT_AXI_AWADDR[2:0],
                              CLINT_AXI_ARADDR[63:16], CLINT_AXI_ARADDR[2:0]};

    // Ready outputs are gated with RSTn so they read 0 while in reset.
    assign CLINT_AXI_AWREADY = RSTn && !awFull_q && !bValid_q;
    assign CLINT_AXI_WREADY  = RSTn && !wFull_q && !bValid_q;
    assign CLINT_AXI_ARREADY = RSTn && !rValid_q;

    assign awHs = CLINT_AXI_AWVALID && CLINT_AXI_AWREADY;
    assign wHs  = CLINT_AXI_WVALID && CLINT_AXI_WREADY;
    assign arHs = CLINT_AXI_ARVALID && CLINT_AXI_ARREADY;

    // The write commits on the edge where both halves are available, taking
    // each half from its holding register or straight from the bus if it is
    // being accepted this cycle. This keeps back-to-back writes at 2 cycles.
    assign doWrite = (awFull_q || awHs) && (wFull_q || wHs);
    assign wrWord  = awFull_q ? awAddr_q : CLINT_AXI_AWADDR[15:3];
    assign wrData  = wFull_q ? wData_q : CLINT_AXI_WDATA;
    assign wrStrb  = wFull_q ? wStrb_q : CLINT_AXI_WSTRB;
    assign wrReg   = decodeWord(wrWord);
    assign mtimeWe = doWrite && (wrReg == REG_MTIME);

    // Write holding registers and write response.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            awFull_q <= 1'b0;
            awAddr_q <= '0;
            wFull_q  <= 1'b0;
            wData_q  <= '0;
            wStrb_q  <= '0;
            bValid_q <= 1'b0;
        end else begin
            if (awHs) begin
                awAddr_q <= CLINT_AXI_AWADDR[15:3];
            end
            if (wHs) begin
                wData_q <= CLINT_AXI_WDATA;
                wStrb_q <= CLINT_AXI_WSTRB;
            end
            awFull_q <= (awFull_q || awHs) && !doWrite;
            wFull_q  <= (wFull_q || wHs) && !doWrite;
            if (doWrite) begin
                bValid_q <= 1'b1;
            end else if (bValid_q && CLINT_AXI_BREADY) begin
                bValid_q <= 1'b0;
            end
        end
    end

    // Software-interrupt and timer-compare registers; msip only listens to byte 0.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            msip_q     <= 1'b0;
            mtimecmp_q <= '1;
        end else if (doWrite) begin
            if (wrReg == REG_MSIP && wrStrb[0]) begin
                msip_q <= wrData[0];
            end
            if (wrReg == REG_MTIMECMP) begin
                mtimecmp_q <= mergeStrb(mtimecmp_q, wrData, wrStrb);
            end
        end
    end

    // Read mux sees pre-write values, so a read racing a write gets the old data.
    always_comb begin
        rdMux = '0;
        case (decodeWord(CLINT_AXI_ARADDR[15:3]))
            REG_MSIP:     rdMux = {{(CLINT_DATA_W-1){1'b0}}, msip_q};
            REG_MTIMECMP: rdMux = mtimecmp_q;
            REG_MTIME:    rdMux = mtime;
            default:      rdMux = '0;
        endcase
    end

    // Read data channel: capture on AR handshake, hold until RREADY.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rValid_q <= 1'b0;
            rData_q  <= '0;
        end else if (arHs) begin
            rValid_q <= 1'b1;
            rData_q  <= rdMux;
        end else if (rValid_q && CLINT_AXI_RREADY) begin
            rValid_q <= 1'b0;
        end
    end

    clint_timer #(
        .RTC_DIV (RTC_DIV)
    ) u_timer (
        .clk_i      (CLK),
        .rst_ni     (RSTn),
        .mtimeWe_i  (mtimeWe),
        .wData_i    (wrData),
        .wStrb_i    (wrStrb),
        .mtimecmp_i (mtimecmp_q),
        .mtime_o    (mtime),
        .mti_o      (MTI)
    );

    assign CLINT_AXI_BVALID = bValid_q;
    assign CLINT_AXI_BRESP  = AXI_RESP_OKAY;
    assign CLINT_AXI_RVALID = rValid_q;
    assign CLINT_AXI_RDATA  = rData_q;
    assign CLINT_AXI_RRESP  = AXI_RESP_OKAY;
    assign MSI              = msip_q;

endmodule

// File: tb/tb_axi_clint.sv
// ---------------------------------------------------------------------------
// tb_axi_clint
// Directed plus randomized bench for axi_clint in its default build (mtime
// advances every clock). A reference model of msip, mtimecmp and mtime is kept
// as plain values plus the edge time at which they were last written; mtime at
// any edge is the written value plus the number of edges elapsed since.
// ---------------------------------------------------------------------------
module tb_axi_clint;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic [63:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [63:0] WDATA = '0;
    logic [7:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [63:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic        MSI;
    logic        MTI;

    axi_clint #(.RTC_DIV(100)) dut (
        .CLK               (CLK),
        .RSTn              (RSTn),
        .CLINT_AXI_AWADDR  (AWADDR),
        .CLINT_AXI_AWVALID (AWVALID),
        .CLINT_AXI_AWREADY (AWREADY),
        .CLINT_AXI_WDATA   (WDATA),
        .CLINT_AXI_WSTRB   (WSTRB),
        .CLINT_AXI_WVALID  (WVALID),
        .CLINT_AXI_WREADY  (WREADY),
        .CLINT_AXI_BRESP   (BRESP),
        .CLINT_AXI_BVALID  (BVALID),
        .CLINT_AXI_BREADY  (BREADY),
        .CLINT_AXI_ARADDR  (ARADDR),
        .CLINT_AXI_ARVALID (ARVALID),
        .CLINT_AXI_ARREADY (ARREADY),
        .CLINT_AXI_RDATA   (RDATA),
        .CLINT_AXI_RRESP   (RRESP),
        .CLINT_AXI_RVALID  (RVALID),
        .CLINT_AXI_RREADY  (RREADY),
        .MSI               (MSI),
        .MTI               (MTI)
    );

    always #5 CLK = ~CLK;

    int  nAssert = 0;
    int  nFail = 0;
    time lastEdge = 0;

    // Reference model state.
    logic        mMsip;
    logic [63:0] mCmp, mCmpOld, mBase, mBaseOld;
    time         mCmpTime, mBaseTime, mBaseOldTime;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        lastEdge = $time;
        #1;
    endtask

    task automatic applyStimulus(input logic awv, input logic [63:0] awa,
                                 input logic wv, input logic [63:0] wd, input logic [7:0] ws,
                                 input logic arv, input logic [63:0] ara);
        AWVALID = awv; AWADDR = awa;
        WVALID  = wv;  WDATA  = wd; WSTRB = ws;
        ARVALID = arv; ARADDR = ara;
    endtask

    function automatic void modelReset(input time t);
        mMsip = 1'b0;
        mCmp = '1; mCmpOld = '1; mCmpTime = t;
        mBase = '0; mBaseOld = '0; mBaseTime = t; mBaseOldTime = t;
    endfunction

    // mtime value just after the clock edge at time t.
    function automatic logic [63:0] mtimeAt(input time t);
        if (t >= mBaseTime) return mBase + 64'((t - mBaseTime) / 10);
        return mBaseOld + 64'((t - mBaseOldTime) / 10);
    endfunction

    function automatic logic [63:0] cmpAt(input time t);
        return (t >= mCmpTime) ? mCmp : mCmpOld;
    endfunction

    // MTI just after edge t reflects the compare of the previous cycle.
    function automatic logic mtiAt(input time t);
        return mtimeAt(t - 10) >= cmpAt(t - 10);
    endfunction

    function automatic logic [63:0] byteMerge(input logic [63:0] o, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] r;
        r = o;
        for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // 0 = unmapped, 1 = msip, 2 = mtimecmp, 3 = mtime
    function automatic int regOf(input logic [63:0] a);
        logic [15:0] ofs;
        ofs = a[15:0] & 16'hFFF8;
        if (ofs == 16'h0000) return 1;
        if (ofs == 16'h4000) return 2;
        if (ofs == 16'hBFF8) return 3;
        return 0;
    endfunction

    function automatic logic [63:0] readModel(input logic [63:0] a, input time t);
        case (regOf(a))
            1: return {63'd0, mMsip};
            2: return mCmp;
            3: return mtimeAt(t);
            default: return 64'd0;
        endcase
    endfunction

    function automatic void writeModel(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s, input time t);
        case (regOf(a))
            1: if (s[0]) mMsip = d[0];
            2: begin
                mCmpOld = mCmp; mCmp = byteMerge(mCmp, d, s); mCmpTime = t;
            end
            3: begin
                logic [63:0] nv;
                nv = byteMerge(mtimeAt(t), d, s);
                mBaseOld = mBase; mBaseOldTime = mBaseTime;
                mBase = nv; mBaseTime = t;
            end
            default: ;
        endcase
    endfunction

    // skew > 0: W leads AW by skew cycles; skew < 0: AW leads W; 0: together.
    // Returns just after the write edge with BVALID expected high.
    task automatic doWrite(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s, input int skew);
        if (skew > 0) begin
            checkOutput("wready_idle", 64'(WREADY), 64'd1);
            applyStimulus(1'b0, '0, 1'b1, d, s, 1'b0, '0);
            stepCycle();
            applyStimulus(1'b0, '0, 1'b0, ~d, ~s, 1'b0, '0);
            checkOutput("wready_held", 64'(WREADY), 64'd0);
            checkOutput("bvalid_early_w", 64'(BVALID), 64'd0);
            repeat (skew - 1) stepCycle();
            checkOutput("awready_late", 64'(AWREADY), 64'd1);
            applyStimulus(1'b1, a, 1'b0, ~d, ~s, 1'b0, '0);
        end else if (skew < 0) begin
            checkOutput("awready_idle", 64'(AWREADY), 64'd1);
            applyStimulus(1'b1, a, 1'b0, '0, '0, 1'b0, '0);
            stepCycle();
            applyStimulus(1'b0, ~a, 1'b0, '0, '0, 1'b0, '0);
            checkOutput("awready_held", 64'(AWREADY), 64'd0);
            checkOutput("bvalid_early_aw", 64'(BVALID), 64'd0);
            repeat ((-skew) - 1) stepCycle();
            checkOutput("wready_late", 64'(WREADY), 64'd1);
            applyStimulus(1'b0, ~a, 1'b1, d, s, 1'b0, '0);
        end else begin
            checkOutput("awready_both", 64'(AWREADY), 64'd1);
            checkOutput("wready_both", 64'(WREADY), 64'd1);
            applyStimulus(1'b1, a, 1'b1, d, s, 1'b0, '0);
        end
        stepCycle();
        writeModel(a, d, s, lastEdge);
        applyStimulus(1'b0, ~a, 1'b0, ~d, ~s, 1'b0, '0);
        checkOutput("bvalid_rise", 64'(BVALID), 64'd1);
        checkOutput("bresp", 64'(BRESP), 64'd0);
    endtask

    task automatic completeWrite();
        BREADY = 1'b1;
        stepCycle();
        BREADY = 1'b0;
        checkOutput("bvalid_clear", 64'(BVALID), 64'd0);
        checkOutput("awready_again", 64'(AWREADY), 64'd1);
        checkOutput("wready_again", 64'(WREADY), 64'd1);
    endtask

    task automatic doRead(input logic [63:0] a, output logic [63:0] got);
        logic [63:0] exp;
        exp = readModel(a, lastEdge);
        checkOutput("arready_idle", 64'(ARREADY), 64'd1);
        ARVALID = 1'b1; ARADDR = a;
        stepCycle();
        ARVALID = 1'b0; ARADDR = ~a;
        checkOutput("rvalid_rise", 64'(RVALID), 64'd1);
        checkOutput("rdata_model", RDATA, exp);
        checkOutput("rresp", 64'(RRESP), 64'd0);
        got = RDATA;
        RREADY = 1'b1;
        stepCycle();
        RREADY = 1'b0;
        checkOutput("rvalid_clear", 64'(RVALID), 64'd0);
        checkOutput("arready_again", 64'(ARREADY), 64'd1);
    endtask

    task automatic checkIrq();
        checkOutput("msi_model", 64'(MSI), 64'(mMsip));
        checkOutput("mti_model", 64'(MTI), 64'(mtiAt(lastEdge)));
    endtask

    initial begin
        logic [63:0] rd;
        logic [63:0] expR;
        logic [63:0] a, d;
        logic [7:0]  s;
        int          k;

        $display("[TB] start");
        #1;
        checkOutput("rst_awready", 64'(AWREADY), 64'd0);
        checkOutput("rst_wready", 64'(WREADY), 64'd0);
        checkOutput("rst_arready", 64'(ARREADY), 64'd0);
        stepCycle();
        stepCycle();
        RSTn = 1'b1;
        modelReset(lastEdge);
        #1;
        checkOutput("rel_awready", 64'(AWREADY), 64'd1);
        checkOutput("rel_wready", 64'(WREADY), 64'd1);
        checkOutput("rel_arready", 64'(ARREADY), 64'd1);
        checkOutput("rst_bvalid", 64'(BVALID), 64'd0);
        checkOutput("rst_rvalid", 64'(RVALID), 64'd0);
        checkOutput("rst_msi", 64'(MSI), 64'd0);
        checkOutput("rst_mti", 64'(MTI), 64'd0);
        checkOutput("rst_rdata", RDATA, 64'd0);
        checkOutput("rst_bresp", 64'(BRESP), 64'd0);
        checkOutput("rst_rresp", 64'(RRESP), 64'd0);
        stepCycle();
        doRead(64'h4000, rd);
        checkOutput("cmp_reset", rd, 64'hFFFF_FFFF_FFFF_FFFF);

        $display("[TB] msip write, AW and W together");
        doWrite(64'h0, 64'h1, 8'hFF, 0);
        checkOutput("msi_set", 64'(MSI), 64'd1);
        completeWrite();
        doRead(64'h0, rd);
        checkOutput("msip_read", rd, 64'h1);

        $display("[TB] W three cycles before AW to mtimecmp");
        doWrite(64'h4000, 64'h20, 8'hFF, 3);
        completeWrite();
        doRead(64'h4000, rd);
        checkOutput("cmp_read_20", rd, 64'h20);

        $display("[TB] timer compare");
        doWrite(64'h4000, 64'h14, 8'hFF, 0);
        completeWrite();
        doWrite(64'hBFF8, 64'h10, 8'hFF, 0);
        for (k = 1; k <= 7; k++) begin
            stepCycle();
            checkOutput("mti_step_model", 64'(MTI), 64'(mtiAt(lastEdge)));
            checkOutput("mti_step_const", 64'(MTI), 64'(k >= 5));
        end
        completeWrite();
        doWrite(64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
        checkOutput("mti_before_drop", 64'(MTI), 64'd1);
        stepCycle();
        checkOutput("mti_drop", 64'(MTI), 64'd0);
        completeWrite();

        $display("[TB] mtime wrap");
        doWrite(64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
        completeWrite();
        doRead(64'hBFF8, rd);
        checkOutput("mtime_wrap", rd, 64'h0);

        $display("[TB] byte strobe on mtimecmp");
        doWrite(64'h4000, 64'hAA, 8'h01, -2);
        completeWrite();
        doRead(64'h4000, rd);
        checkOutput("cmp_byte0", rd, 64'hFFFF_FFFF_FFFF_FFAA);

        $display("[TB] msip partial and empty strobes");
        doWrite(64'h0, 64'h0, 8'hFE, 0);
        completeWrite();
        checkOutput("msi_partial", 64'(MSI), 64'd1);
        doWrite(64'h0, 64'h0, 8'h00, 1);
        completeWrite();
        checkOutput("msi_nostrb", 64'(MSI), 64'd1);
        doWrite(64'h0, 64'h0, 8'h01, 0);
        completeWrite();
        checkOutput("msi_clear", 64'(MSI), 64'd0);

        $display("[TB] read racing write, responses stalled");
        expR = mCmp;
        applyStimulus(1'b1, 64'h4000, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b1, 64'h4000);
        stepCycle();
        writeModel(64'h4000, 64'h1234_5678_9ABC_DEF0, 8'hFF, lastEdge);
        applyStimulus(1'b1, 64'h0, 1'b1, 64'h1, 8'hFF, 1'b1, 64'hBFF8);
        for (k = 0; k < 10; k++) begin
            checkOutput("stall_bvalid", 64'(BVALID), 64'd1);
            checkOutput("stall_rvalid", 64'(RVALID), 64'd1);
            checkOutput("stall_bresp", 64'(BRESP), 64'd0);
            checkOutput("stall_rdata", RDATA, expR);
            checkOutput("stall_awready", 64'(AWREADY), 64'd0);
            checkOutput("stall_wready", 64'(WREADY), 64'd0);
            checkOutput("stall_arready", 64'(ARREADY), 64'd0);
            stepCycle();
        end
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        BREADY = 1'b1; RREADY = 1'b1;
        stepCycle();
        BREADY = 1'b0; RREADY = 1'b0;
        checkOutput("stall_bclear", 64'(BVALID), 64'd0);
        checkOutput("stall_rclear", 64'(RVALID), 64'd0);
        checkOutput("msi_not_written", 64'(MSI), 64'd0);
        doRead(64'h4000, rd);
        checkOutput("cmp_after_race", rd, 64'h1234_5678_9ABC_DEF0);

        $display("[TB] unmapped offset");
        doWrite(64'h8000, 64'hDEAD_BEEF, 8'hFF, 0);
        completeWrite();
        doRead(64'h8000, rd);
        checkOutput("unmapped_read", rd, 64'h0);

        $display("[TB] random traffic");
        for (int n = 0; n < 40; n++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: a[15:3] = 13'h0000;
                1: a[15:3] = 13'h0800;
                2: a[15:3] = 13'h17FF;
                default: ;
            endcase
            d = {$urandom, $urandom};
            s = 8'($urandom);
            if ($urandom_range(0, 2) == 2) begin
                doRead(a, rd);
            end else begin
                doWrite(a, d, s, int'($urandom_range(0, 6)) - 3);
                completeWrite();
            end
            checkIrq();
        end

        $display("[TB] reset mid-transaction");
        doWrite(64'h0, 64'h1, 8'h01, 0);
        completeWrite();
        applyStimulus(1'b1, 64'h0, 1'b0, '0, '0, 1'b0, '0);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        RSTn = 1'b0;
        #1;
        checkOutput("mid_rst_awready", 64'(AWREADY), 64'd0);
        checkOutput("mid_rst_msi", 64'(MSI), 64'd0);
        stepCycle();
        RSTn = 1'b1;
        modelReset(lastEdge);
        #1;
        checkOutput("mid_rel_awready", 64'(AWREADY), 64'd1);
        applyStimulus(1'b0, '0, 1'b1, 64'h1, 8'hFF, 1'b0, '0);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        for (k = 0; k < 3; k++) begin
            checkOutput("no_stale_bvalid", 64'(BVALID), 64'd0);
            checkOutput("no_stale_msi", 64'(MSI), 64'd0);
            stepCycle();
        end
        applyStimulus(1'b1, 64'h8000, 1'b0, '0, '0, 1'b0, '0);
        stepCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
        checkOutput("late_aw_bvalid", 64'(BVALID), 64'd1);
        completeWrite();
        doRead(64'h0, rd);
        checkOutput("msip_after_rst", rd, 64'h0);
        doRead(64'hBFF8, rd);
        checkIrq();

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
